// File: rtl/sqrt_iter_core.sv
// Restoring digit-by-digit integer square root: one root bit per clock,
// start/ready operand handshake, single-cycle valid pulse with held results.
module sqrt_iter_core #(
   parameter int unsigned ROOT_BITS = 26
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     start_i,
   input  logic [2*ROOT_BITS-1:0]   radicand_i,
   output logic                     ready_o,
   output logic                     valid_o,
   output logic [ROOT_BITS-1:0]     root_o,
   output logic [ROOT_BITS:0]       rem_o,
   output logic                     exact_o
);

   localparam int unsigned RAD_W = 2 * ROOT_BITS;
   localparam int unsigned REM_W = ROOT_BITS + 2;
   localparam int unsigned CNT_W = $clog2(ROOT_BITS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [RAD_W-1:0]       rad_q, rad_d;
   logic [ROOT_BITS-1:0]   root_q, root_d;
   logic [REM_W-1:0]       rem_q, rem_d;
   logic [ROOT_BITS-1:0]   root_out_q, root_out_d;
   logic [ROOT_BITS:0]     rem_out_q, rem_out_d;
   logic                   exact_q, exact_d;
   logic                   valid_q, valid_d;
   logic                   ready_q, ready_d;

   // One restoring step; the working remainder never needs more than ROOT_BITS+2 bits.
   logic [REM_W-1:0]       rem_shift;
   logic [REM_W-1:0]       trial;
   logic                   take;
   logic [REM_W-1:0]       rem_next;
   logic [ROOT_BITS-1:0]   root_next;

   always_comb begin
      rem_shift = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
      trial     = {root_q, 2'b01};
      take      = (rem_shift >= trial);
      rem_next  = take ? (rem_shift - trial) : rem_shift;
      root_next = {root_q[ROOT_BITS-2:0], take};
   end

   always_comb begin
      // NOTE: every _d starts from its _q (or a pulse default) so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      rad_d      = rad_q;
      root_d     = root_q;
      rem_d      = rem_q;
      root_out_d = root_out_q;
      rem_out_d  = rem_out_q;
      exact_d    = exact_q;
      valid_d    = 1'b0;

      if (flush_i) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         rad_d      = '0;
         root_d     = '0;
         rem_d      = '0;
         root_out_d = '0;
         rem_out_d  = '0;
         exact_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_d = S_CALC;
                  cnt_d   = CNT_W'(ROOT_BITS - 1);
                  rad_d   = radicand_i;
                  root_d  = '0;
                  rem_d   = '0;
               end
            end
            S_CALC: begin
               rad_d  = {rad_q[RAD_W-3:0], 2'b00};
               root_d = root_next;
               rem_d  = rem_next;
               if (cnt_q == '0) begin
                  state_d    = S_DONE;
                  valid_d    = 1'b1;
                  root_out_d = root_next;
                  rem_out_d  = rem_next[ROOT_BITS:0];
                  exact_d    = (rem_next == '0);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      ready_d = (state_d == S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rad_q      <= '0;
         root_q     <= '0;
         rem_q      <= '0;
         root_out_q <= '0;
         rem_out_q  <= '0;
         exact_q    <= 1'b0;
         valid_q    <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rad_q      <= rad_d;
         root_q     <= root_d;
         rem_q      <= rem_d;
         root_out_q <= root_out_d;
         rem_out_q  <= rem_out_d;
         exact_q    <= exact_d;
         valid_q    <= valid_d;
         ready_q    <= ready_d;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign root_o  = root_out_q;
   assign rem_o   = rem_out_q;
   assign exact_o = exact_q;

endmodule

// File: doc/sqrt_iter_core.md
Name: sqrt_iter_core

Overview:
Iterative restoring digit-by-digit integer square-root engine for the F-extension FSQRT path in the block_sqrt group. It takes a 2*ROOT_BITS-bit pre-normalised mantissa radicand and produces the floor root and the remainder, one root bit per cycle. It sits between the operand-unpack stage and the rounding/pack stage. It reads its operand under a start/ready handshake and delivers the result with a one-cycle valid pulse. Its state and result holding use the group's enable/clear register style.

Parameters:
ROOT_BITS, 26, root width; radicand is 2*ROOT_BITS bits, remainder is ROOT_BITS+1 bits.

Ports:
clk  in  1  clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
flush_i  in  1  synchronous kill (pipeline flush), highest priority after reset.
start_i  in  1  request; accepted only when ready_o=1.
radicand_i  in  2*ROOT_BITS  operand, sampled on the accepting edge.
ready_o  out  1  high only in IDLE.
valid_o  out  1  one-cycle result pulse.
root_o  out  ROOT_BITS  floor(sqrt(radicand)).
rem_o  out  ROOT_BITS+1  radicand - root^2.
exact_o  out  1  rem_o==0; feeds the sticky bit.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ready_o=1, valid_o=0.
  - root_o=0, rem_o=0, exact_o=0.
  - All internal working registers cleared.
- States: IDLE, CALC, DONE.
  - IDLE: if start_i=1 and flush_i=0, load radicand into the shift register, clear partial root/remainder, set iteration counter=ROOT_BITS-1, go to CALC.
  - CALC: one iteration per edge.
    - rem' = (rem<<2) | top two radicand bits; shift radicand left by 2.
    - trial = (root<<2)|1.
    - If rem' >= trial: rem=rem'-trial, root=(root<<1)|1. Else: rem=rem', root=root<<1.
    - When counter==0: the final iteration's results are written to root_o/rem_o/exact_o on the same edge, and the block goes to DONE. Otherwise decrement the counter.
  - DONE: valid_o=1 for exactly this cycle; next edge to IDLE unconditionally.
- Timing:
  - start sampled at edge t.
  - ROOT_BITS iterations at edges t+1..t+ROOT_BITS.
  - valid_o high in the cycle after edge t+ROOT_BITS.
  - ready_o low from edge t through edge t+ROOT_BITS+1.
  - Minimum start-to-start spacing is ROOT_BITS+2 cycles.
- Width rules:
  - Working remainder is ROOT_BITS+2 bits; the compare/subtract is unsigned at that width.
  - The final remainder always fits ROOT_BITS+1 bits (max 2*root).
- Output holding: root_o/rem_o/exact_o change only on the completing edge, on flush, or on reset. They are held through IDLE until the next completion.
- start_i outside IDLE: ignored, with no side effect on the in-flight operation.
- flush_i=1 in any state, at the next edge:
  - state=IDLE, valid_o=0.
  - root_o/rem_o/exact_o cleared to 0; working registers cleared.
  - A start_i in the same cycle is dropped.
- flush_i in the DONE cycle: valid_o remains high during that cycle (already registered), and the outputs clear at the edge.
- Reset mid-CALC: operation abandoned, no valid_o pulse; outputs return to reset values immediately.
- radicand_i changing after acceptance has no effect.

Test Plan:
- Basic and exact results:
  - radicand=144 -> valid_o exactly ROOT_BITS cycles after the accept edge (one-cycle pulse).
  - Response: root_o=12, rem_o=0, exact_o=1.
  - radicand=0 -> root_o=0, rem_o=0, exact_o=1.
- Non-exact and maximum:
  - radicand=2 -> root_o=1, rem_o=1, exact_o=0.
  - radicand=2^52-1 -> root_o=67108863, rem_o=134217726, exact_o=0.
- Handshake: pulse start_i (radicand=100) on every cycle while busy.
  - Exactly one result: root_o=10, rem_o=0.
  - ready_o low for ROOT_BITS+1 cycles.
  - Outputs then hold 10/0 in IDLE until the next completion.
- Back-to-back: radicand=49 accepted, then 50 accepted in the first IDLE cycle after DONE -> results 7/0 then 7/1, two valid pulses ROOT_BITS+2 cycles apart.
- Flush:
  - flush_i at iteration 10 of radicand=1000 -> no valid_o; outputs=0; ready_o=1 the next cycle.
  - flush_i together with a start_i in IDLE -> start dropped.
- Reset: rst_n low asynchronously mid-CALC (between edges) -> outputs 0 and ready_o=1 immediately, no valid_o. After release, radicand=81 gives 9/0.
